// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the multi-channel FIFO and its bench.
// Holds the default geometry, a constant-foldable clog2 and the count-slice index helper.
package fifo_pkg;

    localparam int unsigned DEF_DATA_SIZE = 8;
    localparam int unsigned DEF_ADDR_SIZE = 4;
    localparam int unsigned DEF_NUM_CH    = 4;

    // Bounded loop so the function folds at elaboration and stays synthesizable.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic int unsigned cnt_lsb(input int unsigned ch, input int unsigned addr_size);
        return ch * (addr_size + 32'd1);
    endfunction

endpackage

// File: rtl/fifo_ch_ptr.sv
// Pointer pair for one FIFO channel: wrap-bit pointers, full/empty/count, and flush.
module fifo_ch_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_inc_i,
    input  logic                 rd_inc_i,
    input  logic                 flush_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [ADDR_SIZE:0]   count_o,
    output logic [ADDR_SIZE-1:0] waddr_o,
    output logic [ADDR_SIZE-1:0] raddr_o
);

    logic [ADDR_SIZE:0] wptr_q;
    logic [ADDR_SIZE:0] wptr_d;
    logic [ADDR_SIZE:0] rptr_q;
    logic [ADDR_SIZE:0] rptr_d;

    // Next-state pointers; flush overrides any increment on this channel.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_inc_i) begin
                wptr_d = wptr_q + {{ADDR_SIZE{1'b0}}, 1'b1};
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_inc_i) begin
                rptr_d = rptr_q + {{ADDR_SIZE{1'b0}}, 1'b1};
            end else begin
                rptr_d = rptr_q;
            end
        end
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Status decode: the wrap bit distinguishes full from empty when low bits match.
    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[ADDR_SIZE] != rptr_q[ADDR_SIZE]) &&
                  (wptr_q[ADDR_SIZE-1:0] == rptr_q[ADDR_SIZE-1:0]);
        count_o = wptr_q - rptr_q;
        waddr_o = wptr_q[ADDR_SIZE-1:0];
        raddr_o = rptr_q[ADDR_SIZE-1:0];
    end

endmodule

// File: rtl/fifo_mc_memory.sv
// Multi-channel FIFO: one shared array carved into NUM_CH circular queues,
// a single write port, a single registered read port, per-channel flush and sticky errors.
module fifo_mc_memory
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter  int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
    parameter  int unsigned NUM_CH    = DEF_NUM_CH,
    localparam int unsigned CH_BITS   = clog2(NUM_CH)
) (
    input  logic                            wclk,
    input  logic                            wrst_n,
    input  logic                            wr_en,
    input  logic [CH_BITS-1:0]              wr_ch,
    input  logic [DATA_SIZE-1:0]            wdata,
    input  logic                            rd_en,
    input  logic [CH_BITS-1:0]              rd_ch,
    output logic [DATA_SIZE-1:0]            rdata,
    output logic                            rvalid,
    input  logic                            flush_en,
    input  logic [CH_BITS-1:0]              flush_ch,
    output logic [NUM_CH-1:0]               full,
    output logic [NUM_CH-1:0]               empty,
    output logic [NUM_CH*(ADDR_SIZE+1)-1:0] count,
    output logic                            ovf_err,
    output logic                            udf_err
);

    localparam int unsigned DEPTH = NUM_CH << ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem_q [0:DEPTH-1];

    logic [NUM_CH-1:0]                 full_s;
    logic [NUM_CH-1:0]                 empty_s;
    logic [NUM_CH-1:0][ADDR_SIZE:0]    cnt_s;
    logic [NUM_CH-1:0][ADDR_SIZE-1:0]  wlo_s;
    logic [NUM_CH-1:0][ADDR_SIZE-1:0]  rlo_s;
    logic [NUM_CH-1:0]                 wr_inc_s;
    logic [NUM_CH-1:0]                 rd_inc_s;
    logic [NUM_CH-1:0]                 flush_s;

    logic                      wr_flush_hit_s;
    logic                      rd_flush_hit_s;
    logic                      wr_acc_s;
    logic                      rd_acc_s;
    logic                      ovf_set_s;
    logic                      udf_set_s;
    logic [CH_BITS+ADDR_SIZE-1:0] waddr_s;
    logic [CH_BITS+ADDR_SIZE-1:0] raddr_s;

    logic [DATA_SIZE-1:0] rdata_q;
    logic [DATA_SIZE-1:0] rdata_d;
    logic                 rvalid_q;
    logic                 rvalid_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 udf_q;
    logic                 udf_d;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            localparam int unsigned LSB = cnt_lsb(c, ADDR_SIZE);

            fifo_ch_ptr #(
                .ADDR_SIZE (ADDR_SIZE)
            ) u_ptr (
                .clk_i    (wclk),
                .rst_ni   (wrst_n),
                .wr_inc_i (wr_inc_s[c]),
                .rd_inc_i (rd_inc_s[c]),
                .flush_i  (flush_s[c]),
                .full_o   (full_s[c]),
                .empty_o  (empty_s[c]),
                .count_o  (cnt_s[c]),
                .waddr_o  (wlo_s[c]),
                .raddr_o  (rlo_s[c])
            );

            assign count[LSB +: ADDR_SIZE+1] = cnt_s[c];
        end
    endgenerate

    // Request decode on pre-edge flags; a flush of the addressed channel swallows the request.
    always_comb begin
        wr_flush_hit_s = flush_en && (flush_ch == wr_ch);
        rd_flush_hit_s = flush_en && (flush_ch == rd_ch);
        wr_acc_s  = wr_en && !full_s[wr_ch]  && !wr_flush_hit_s;
        rd_acc_s  = rd_en && !empty_s[rd_ch] && !rd_flush_hit_s;
        ovf_set_s = wr_en && full_s[wr_ch]   && !wr_flush_hit_s;
        udf_set_s = rd_en && empty_s[rd_ch]  && !rd_flush_hit_s;
        waddr_s   = {wr_ch, wlo_s[wr_ch]};
        raddr_s   = {rd_ch, rlo_s[rd_ch]};
        wr_inc_s  = '0;
        rd_inc_s  = '0;
        flush_s   = '0;
        if (wr_acc_s) begin
            wr_inc_s[wr_ch] = 1'b1;
        end else begin
            wr_inc_s = '0;
        end
        if (rd_acc_s) begin
            rd_inc_s[rd_ch] = 1'b1;
        end else begin
            rd_inc_s = '0;
        end
        if (flush_en) begin
            flush_s[flush_ch] = 1'b1;
        end else begin
            flush_s = '0;
        end
    end

    // Shared storage; not reset, and writes are blocked while reset is asserted.
    always_ff @(posedge wclk) begin
        if (wrst_n && wr_acc_s) begin
            mem_q[waddr_s] <= wdata;
        end
    end

    // Next-state for the read register and the sticky error flags.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_acc_s;
        ovf_d    = ovf_q | ovf_set_s;
        udf_d    = udf_q | udf_set_s;
        if (rd_acc_s) begin
            rdata_d = mem_q[raddr_s];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Registered read path and error flags.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign full    = full_s;
    assign empty   = empty_s;
    assign ovf_err = ovf_q;
    assign udf_err = udf_q;

endmodule

// File: tb/tb_fifo_mc_memory.sv
// Directed bench for fifo_mc_memory at default geometry (8-bit data, 16 deep, 4 channels).
module tb_fifo_mc_memory;
    import fifo_pkg::*;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [7:0]  wdata;
    logic        rd_en;
    logic [1:0]  rd_ch;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        flush_en;
    logic [1:0]  flush_ch;
    logic [3:0]  full;
    logic [3:0]  empty;
    logic [19:0] count;
    logic        ovf_err;
    logic        udf_err;

    int checks   = 0;
    int failures = 0;

    fifo_mc_memory dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wdata    (wdata),
        .rd_en    (rd_en),
        .rd_ch    (rd_ch),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .flush_en (flush_en),
        .flush_ch (flush_ch),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] cnt(input int ch);
        return count[cnt_lsb(ch, 4) +: 5];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] d);
        wr_en = 1'b1; wr_ch = ch; wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_expect(input string tag, input logic [1:0] ch, input logic [7:0] exp);
        rd_en = 1'b1; rd_ch = ch;
        tick();
        rd_en = 1'b0;
        check({tag, "_rvalid"}, rvalid, 1'b1);
        check({tag, "_rdata"}, rdata, exp);
    endtask

    initial begin
        wrst_n = 1'b0; wr_en = 1'b1; wr_ch = 2'd0; wdata = 8'h55;
        rd_en = 1'b0; rd_ch = 2'd0; flush_en = 1'b0; flush_ch = 2'd0;

        // Reset with a write request held high
        tick(); tick();
        check("rst_empty", empty, 4'b1111);
        check("rst_full", full, 4'b0000);
        check("rst_count", count, 20'd0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_ovf", ovf_err, 1'b0);
        check("rst_udf", udf_err, 1'b0);
        wrst_n = 1'b1; wr_en = 1'b0;
        tick();
        check("rst_nowrite", empty[0], 1'b1);

        // Fill ch2
        for (int i = 0; i < 16; i++) wr(2'd2, 8'(i));
        check("fill_full", full, 4'b0100);
        check("fill_count2", cnt(2), 5'd16);
        check("fill_ovf0", ovf_err, 1'b0);
        wr(2'd2, 8'hAA);
        check("ovf_set", ovf_err, 1'b1);
        check("ovf_count2", cnt(2), 5'd16);

        // Drain ch2 with one-cycle rvalid pulses
        for (int i = 0; i < 16; i++) begin
            rd_expect("drain2", 2'd2, 8'(i));
            tick();
            check("drain2_pulse", rvalid, 1'b0);
            check("drain2_hold", rdata, 8'(i));
        end
        check("drain2_empty", empty[2], 1'b1);
        check("drain2_count", cnt(2), 5'd0);

        // Channel isolation
        wr(2'd0, 8'hA1);
        wr(2'd3, 8'hB1);
        wr(2'd0, 8'hA2);
        check("iso_count0", cnt(0), 5'd2);
        check("iso_count3", cnt(3), 5'd1);
        check("iso_count1a", cnt(1), 5'd0);
        rd_expect("iso_ch3", 2'd3, 8'hB1);
        rd_expect("iso_ch0a", 2'd0, 8'hA1);
        rd_expect("iso_ch0b", 2'd0, 8'hA2);
        check("iso_count1b", cnt(1), 5'd0);

        // Wrap with concurrent read/write on ch1
        for (int i = 0; i < 5; i++) wr(2'd1, 8'(i));
        check("wrap_pre", cnt(1), 5'd5);
        wr_en = 1'b1; wr_ch = 2'd1; rd_en = 1'b1; rd_ch = 2'd1;
        for (int i = 0; i < 40; i++) begin
            wdata = 8'(5 + i);
            tick();
            check("wrap_rvalid", rvalid, 1'b1);
            check("wrap_rdata", rdata, 8'(i));
            check("wrap_count1", cnt(1), 5'd5);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        for (int i = 0; i < 5; i++) rd_expect("wrap_tail", 2'd1, 8'(40 + i));
        check("wrap_empty", empty[1], 1'b1);
        check("wrap_udf", udf_err, 1'b0);

        // Flush ch0 with same-cycle write and read; ch3 untouched
        wr(2'd0, 8'hC0); wr(2'd0, 8'hC1); wr(2'd0, 8'hC2); wr(2'd3, 8'hE3);
        check("fl_pre", cnt(0), 5'd3);
        flush_en = 1'b1; flush_ch = 2'd0;
        wr_en = 1'b1; wr_ch = 2'd0; wdata = 8'hDD; rd_en = 1'b1; rd_ch = 2'd0;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("fl_count0", cnt(0), 5'd0);
        check("fl_empty0", empty[0], 1'b1);
        check("fl_rvalid", rvalid, 1'b0);
        check("fl_ovf", ovf_err, 1'b1);
        check("fl_count3", cnt(3), 5'd1);
        rd_en = 1'b1; rd_ch = 2'd0;
        tick();
        flush_en = 1'b0; rd_en = 1'b0;
        check("fl_udf", udf_err, 1'b0);
        wr(2'd0, 8'hF0);
        rd_expect("fl_after0", 2'd0, 8'hF0);
        rd_expect("fl_ch3", 2'd3, 8'hE3);

        // Underflow
        rd_en = 1'b1; rd_ch = 2'd1;
        tick();
        rd_en = 1'b0;
        check("udf_set", udf_err, 1'b1);
        check("udf_rvalid", rvalid, 1'b0);

        // Reset right after an accepted read, with a further read pending
        wr(2'd3, 8'h77);
        wr(2'd2, 8'h78);
        rd_en = 1'b1; rd_ch = 2'd3;
        tick();
        check("mid_rvalid", rvalid, 1'b1);
        rd_ch = 2'd2;
        wrst_n = 1'b0;
        tick();
        rd_en = 1'b0;
        check("mid_rst_rvalid", rvalid, 1'b0);
        check("mid_rst_rdata", rdata, 8'h00);
        check("mid_rst_ovf", ovf_err, 1'b0);
        check("mid_rst_udf", udf_err, 1'b0);
        check("mid_rst_empty", empty, 4'b1111);
        check("mid_rst_count", count, 20'd0);
        wrst_n = 1'b1;
        tick();
        check("post_rst_rvalid", rvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
